// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Brief    : Shared types and constants for the nibble-serial comparator.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Comparator control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one comparator slice.
  localparam int CMP_NIB_W = 4;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/four_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_comparator
// Brief    : Unsigned 4-bit magnitude comparator slice (one-hot result).
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agb,
  output logic       aeb,
  output logic       alb
);

  // Pure combinational magnitude compare.
  always_comb begin
    agb = (a > b);
    aeb = (a == b);
    alb = (a < b);
  end

endmodule : four_bit_comparator
`default_nettype wire

// File: rtl/nibble_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_comparator
// Brief    : Sequential WIDTH-bit magnitude comparator. Scans the operands
//            MSB-first one nibble per clock through a single shared slice and
//            stops at the first differing nibble.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4,
  localparam int CW    = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agb,
  output logic             aeb,
  output logic             alb,
  output logic [CW-1:0]    nib_count
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] C_IDX_TOP = IW'(NIB - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_signed;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic                 r_agb;
  logic                 r_aeb;
  logic                 r_alb;
  logic [CW-1:0]        r_cnt;
  logic                 w_agb_nxt;
  logic                 w_aeb_nxt;
  logic                 w_alb_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_load;

  logic [IW+1:0]        w_bit_base;
  logic [CMP_NIB_W-1:0] w_nib_a;
  logic [CMP_NIB_W-1:0] w_nib_b;
  logic                 w_bias;
  logic [CMP_NIB_W-1:0] w_slice_a;
  logic [CMP_NIB_W-1:0] w_slice_b;
  logic                 w_slice_agb;
  logic                 w_slice_aeb;
  logic                 w_slice_alb;

  // Select the current nibble; flipping the sign bit of the top nibble turns
  // a two's-complement compare into an unsigned one for that nibble only.
  always_comb begin
    w_bit_base = {r_idx, 2'b00};
    w_nib_a    = r_a[w_bit_base +: CMP_NIB_W];
    w_nib_b    = r_b[w_bit_base +: CMP_NIB_W];
    w_bias     = r_signed && (r_idx == C_IDX_TOP);
    w_slice_a  = {w_nib_a[3] ^ w_bias, w_nib_a[2:0]};
    w_slice_b  = {w_nib_b[3] ^ w_bias, w_nib_b[2:0]};
  end

  four_bit_comparator u_slice (
    .a   (w_slice_a),
    .b   (w_slice_b),
    .agb (w_slice_agb),
    .aeb (w_slice_aeb),
    .alb (w_slice_alb)
  );

  // Next-state and result-update logic for the scan.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_agb_nxt   = r_agb;
    w_aeb_nxt   = r_aeb;
    w_alb_nxt   = r_alb;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_idx_nxt   = C_IDX_TOP;
          w_state_nxt = CMP;
        end
      end
      CMP: begin
        if (w_slice_agb || w_slice_alb) begin
          w_agb_nxt   = w_slice_agb;
          w_aeb_nxt   = 1'b0;
          w_alb_nxt   = w_slice_alb;
          w_cnt_nxt   = CW'(NIB) - CW'(r_idx);
          w_state_nxt = DONE;
        end else if (w_slice_aeb && (r_idx == '0)) begin
          w_agb_nxt   = 1'b0;
          w_aeb_nxt   = 1'b1;
          w_alb_nxt   = 1'b0;
          w_cnt_nxt   = CW'(NIB);
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, scan index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_agb    <= 1'b0;
      r_aeb    <= 1'b0;
      r_alb    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_load) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= signed_mode;
      end
      r_idx <= w_idx_nxt;
      r_agb <= w_agb_nxt;
      r_aeb <= w_aeb_nxt;
      r_alb <= w_alb_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign agb       = r_agb;
  assign aeb       = r_aeb;
  assign alb       = r_alb;
  assign nib_count = r_cnt;

endmodule : nibble_serial_comparator
`default_nettype wire

// File: doc/nibble_serial_comparator.md
Name: nibble_serial_comparator

Overview:
- Sequential magnitude comparator for WIDTH-bit operands, built on one shared `four_bit_comparator` nibble slice.
- Captures an operand pair through a valid/ready handshake and scans nibbles MSB-first, one per clock.
- Stops at the first unequal nibble and returns a one-hot AGB/AEB/ALB result plus the count of nibbles examined.
- Sits between a requester (e.g. a sort/min-max engine) and the comparator datapath, trading latency for area.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibbles; localparam, not overridable.
- CW, $clog2(NIB+1), width of nib_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- agb  output  1  A > B.
- aeb  output  1  A == B.
- alb  output  1  A < B.
- nib_count  output  CW  nibbles examined, 1..NIB.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous active-low, with ports named clk and rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, agb=aeb=alb=0, nib_count=0. Internal operand registers and index cleared.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T, register a, b and signed_mode; set idx=NIB-1 and go to CMP.
- CMP, one nibble per cycle:
  - Comparator inputs are a_r[4*idx+:4] and b_r[4*idx+:4].
  - When idx==NIB-1 and signed_mode=1, bit 3 of both nibbles is inverted before comparison (sign-bias). No other nibble is modified.
  - If the slice reports AGB or ALB: register that flag, set aeb=0, nib_count=NIB-idx, go to DONE.
  - Else if idx==0: register aeb=1, nib_count=NIB, go to DONE.
  - Else: decrement idx and stay in CMP.
- Latency:
  - With k nibbles examined, the result registers on edge T+k and out_valid is high from T+k.
  - Minimum latency is 1 cycle; maximum is NIB.
- DONE:
  - out_valid=1; agb/aeb/alb/nib_count stable.
  - On out_valid&out_ready, go to IDLE with out_valid=0. Result flags hold their last value but are meaningful only while out_valid is high.
- Exactly one of agb/aeb/alb is high whenever out_valid=1.
- Handshake rules:
  - in_valid outside IDLE is ignored; no operand is captured.
  - Input changes after capture have no effect.
  - A new operand pair cannot be accepted on the same edge a result is accepted. Throughput is one comparison per k+2 cycles minimum.
- Reset mid-operation: assertion in CMP or DONE immediately forces reset values. The in-flight comparison is lost and no result is emitted.
- Out of scope: X on a/b while in_valid=0.

Decomposition:
- Package `cmp_pkg`: state enum (IDLE, CMP, DONE) and a `CMP_NIB_W=4` constant.
- One sub-module: the existing `four_bit_comparator`, instantiated once as the nibble datapath.
- FSM, index counter and sign-bias logic live in `nibble_serial_comparator`.

Test Plan (WIDTH=16):
- Equal operands: a=0x1234, b=0x1234, unsigned; out_ready=1 → aeb=1, nib_count=4, out_valid at T+4 for one cycle, then in_ready=1.
- Early exit, unsigned: a=0x9000, b=0x1FFF → agb=1, nib_count=1, out_valid at T+1.
- Same pair, signed_mode=1 → alb=1, nib_count=1 (negative < positive).
- Last-nibble difference: a=0x1235, b=0x1234 → agb=1, nib_count=4. Also a=0xFFFE, b=0xFFFF signed → alb=1, nib_count=4.
- Backpressure: a=0x0001, b=0x0002 with out_ready=0 for 5 cycles, in_valid held high with new data 0xAAAA/0x5555:
  - alb=1 and nib_count=4 stay stable; in_ready=0 throughout; new data not captured.
  - After out_ready=1 and the return to IDLE, 0xAAAA/0x5555 is accepted and gives agb=1 (unsigned).
- Reset mid-CMP: a=0x1111, b=0x1111; assert rst_n=0 asynchronously at T+2 →
  - out_valid, agb, aeb, alb and nib_count go to 0 immediately, in_ready=1.
  - After release, no stale result appears and the next compare behaves normally.
